// File: rtl/ecc_cmd_issuer_pkg.sv
// rtl/ecc_cmd_issuer_pkg.sv - ECC op codes and issuer state encodings
package ecc_cmd_issuer_pkg;

  // Operation codes shared with the ECC control unit
  typedef enum logic [1:0] {
    ECDH_SK    = 2'b00,
    ECDSA_SIGN = 2'b01,
    ECDSA_VERI = 2'b10,
    ECDH_PK    = 2'b11
  } ecc_op_e;

  localparam int ECC_OP_W = 2;

  // One-hot issuer states
  localparam logic [5:0] S_IDLE      = 6'b000001;
  localparam logic [5:0] S_ISSUE     = 6'b000010;
  localparam logic [5:0] S_WAIT_ACK  = 6'b000100;
  localparam logic [5:0] S_WAIT_DONE = 6'b001000;
  localparam logic [5:0] S_CLEAR     = 6'b010000;
  localparam logic [5:0] S_CLR_WAIT  = 6'b100000;

endpackage

// File: rtl/ecc_cmd_issuer.sv
// rtl/ecc_cmd_issuer.sv - issues one ECC command to the core, with timeout and abort recovery
module ecc_cmd_issuer
  import ecc_cmd_issuer_pkg::*;
#(
  parameter int              TO_W   = 24,
  parameter logic [TO_W-1:0] TO_MAX = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [ECC_OP_W-1:0] cmd_op,
  input  logic                cmd_abort,
  output logic                cmd_ready,
  output logic                busy,
  output logic                done,
  output logic [ECC_OP_W-1:0] done_op,
  output logic                err_to,
  output logic                err_abort,
  input  logic                sts_clr,
  output logic [ECC_OP_W-1:0] ecc_op,
  output logic                ecc_en,
  output logic                ecc_clr,
  input  logic                ecc_rdy
);

  logic [5:0]          r_state;
  logic [5:0]          w_state_nxt;
  logic [ECC_OP_W-1:0] r_op_q;
  logic [TO_W-1:0]     r_cnt;
  logic [TO_W-1:0]     w_cnt_nxt;
  logic                r_done;
  logic [ECC_OP_W-1:0] r_done_op;
  logic                r_err_to;
  logic                r_err_abort;
  logic                w_idle;
  logic                w_active;
  logic                w_to;
  logic                w_ab;
  logic                w_kill;
  logic                w_accept;
  logic                w_done_ev;

  assign w_idle    = (r_state == S_IDLE);
  assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE);
  assign w_accept  = w_idle && cmd_valid;
  assign w_cnt_nxt = (r_cnt == {TO_W{1'b1}}) ? r_cnt : r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
  // Timeout fires on the cycle whose count would reach TO_MAX
  assign w_to      = w_active && (w_cnt_nxt == TO_MAX);
  // Abort is only meaningful while a command is in flight
  assign w_ab      = w_active && cmd_abort;
  assign w_kill    = w_to || w_ab;
  // A kill in the same cycle as the core finishing suppresses done
  assign w_done_ev = (r_state == S_WAIT_DONE) && ecc_rdy && !w_kill;

  // Next-state selection; timeout/abort overrides every normal transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (cmd_valid) w_state_nxt = S_ISSUE;
      S_ISSUE:     if (ecc_rdy)   w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (!ecc_rdy)  w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (ecc_rdy)   w_state_nxt = S_IDLE;
      S_CLEAR:                    w_state_nxt = S_CLR_WAIT;
      S_CLR_WAIT:  if (ecc_rdy)   w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
    if (w_kill) w_state_nxt = S_CLEAR;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch op on acceptance; timeout counter restarts per command and saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_op_q <= cmd_op;
      r_cnt  <= '0;
    end else if (w_active) begin
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Completion pulse and the op of the last completed or cleared command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_done_op <= '0;
    end else begin
      r_done <= w_done_ev;
      if (w_done_ev || w_kill) r_done_op <= r_op_q;
    end
  end

  // Sticky error flags; a new set event beats sts_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_to    <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      if (w_to)         r_err_to    <= 1'b1;
      else if (sts_clr) r_err_to    <= 1'b0;
      if (w_ab)         r_err_abort <= 1'b1;
      else if (sts_clr) r_err_abort <= 1'b0;
    end
  end

  assign cmd_ready = w_idle;
  assign busy      = !w_idle;
  assign done      = r_done;
  assign done_op   = r_done_op;
  assign err_to    = r_err_to;
  assign err_abort = r_err_abort;
  assign ecc_op    = w_idle ? ECDH_SK : r_op_q;
  assign ecc_en    = (r_state == S_ISSUE) && ecc_rdy && !w_kill;
  assign ecc_clr   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_ecc_cmd_issuer.sv
// tb/tb_ecc_cmd_issuer.sv - directed self-checking bench for ecc_cmd_issuer
module tb_ecc_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, t_cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_abort;
  logic       sts_clr;
  logic       ecc_rdy, t_ecc_rdy;

  logic       cmd_ready, busy, done, err_to, err_abort, ecc_en, ecc_clr;
  logic [1:0] done_op, ecc_op;
  logic       t_cmd_ready, t_busy, t_done, t_err_to, t_err_abort, t_ecc_en, t_ecc_clr;
  logic [1:0] t_done_op, t_ecc_op;

  int n_vec = 0;
  int n_err = 0;
  int n_cnt;
  int n_aux;

  always #5 clk = ~clk;

  ecc_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_abort(cmd_abort), .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .done_op(done_op), .err_to(err_to), .err_abort(err_abort), .sts_clr(sts_clr),
    .ecc_op(ecc_op), .ecc_en(ecc_en), .ecc_clr(ecc_clr), .ecc_rdy(ecc_rdy)
  );

  ecc_cmd_issuer #(.TO_W(24), .TO_MAX(24'd16)) dut_to (
    .clk(clk), .rst_n(rst_n), .cmd_valid(t_cmd_valid), .cmd_op(cmd_op),
    .cmd_abort(cmd_abort), .cmd_ready(t_cmd_ready), .busy(t_busy), .done(t_done),
    .done_op(t_done_op), .err_to(t_err_to), .err_abort(t_err_abort), .sts_clr(sts_clr),
    .ecc_op(t_ecc_op), .ecc_en(t_ecc_en), .ecc_clr(t_ecc_clr), .ecc_rdy(t_ecc_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; t_cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_abort = 1'b0; sts_clr = 1'b0; ecc_rdy = 1'b0; t_ecc_rdy = 1'b0;
    tick; tick;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_op", done_op, 0);
    chk("rst_flags", {err_to, err_abort}, 0);
    chk("rst_strobes", {ecc_en, ecc_clr}, 0);
    chk("rst_ecc_op", ecc_op, 0);
    rst_n = 1'b1;

    // Sign command, core ready at once, long core busy phase
    cmd_op = 2'd1; cmd_valid = 1'b1; ecc_rdy = 1'b1;
    #1 chk("t1_ready", cmd_ready, 1);
    tick; cmd_valid = 1'b0;
    chk("t1_en", ecc_en, 1);
    chk("t1_op", ecc_op, 1);
    chk("t1_busy", {busy, cmd_ready}, 2'b10);
    tick;
    chk("t1_ack_en", ecc_en, 0);
    chk("t1_ack_op", ecc_op, 1);
    ecc_rdy = 1'b0;
    tick;
    cmd_valid = 1'b1; cmd_op = 2'd3;
    n_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      cmd_valid = 1'b0; cmd_op = 2'd1;
      if (done) n_cnt++;
    end
    chk("t1_nodone", n_cnt, 0);
    chk("t1_busy_wait", busy, 1);
    ecc_rdy = 1'b1;
    tick;
    chk("t1_done", done, 1);
    chk("t1_done_op", done_op, 1);
    chk("t1_idle", busy, 0);
    tick;
    chk("t1_done_pulse", done, 0);

    // Verify command issued while core not ready
    cmd_op = 2'd2; cmd_valid = 1'b1; ecc_rdy = 1'b0;
    tick; cmd_valid = 1'b0;
    n_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (ecc_en) n_cnt++;
      tick;
    end
    chk("t2_en_held", n_cnt, 0);
    ecc_rdy = 1'b1;
    #1 chk("t2_en_on", ecc_en, 1);
    n_cnt = 1;
    tick; if (ecc_en) n_cnt++;
    tick; if (ecc_en) n_cnt++;
    chk("t2_en_count", n_cnt, 1);
    ecc_rdy = 1'b0;
    tick;
    ecc_rdy = 1'b1;
    tick;
    chk("t2_done", done, 1);
    chk("t2_done_op", done_op, 2);

    // Timeout with TO_MAX=16 on the second instance
    cmd_op = 2'd3; t_cmd_valid = 1'b1; t_ecc_rdy = 1'b0;
    tick; t_cmd_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick;
    chk("t3_pre_to", t_err_to, 0);
    chk("t3_pre_busy", t_busy, 1);
    tick;
    chk("t3_err_to", t_err_to, 1);
    chk("t3_clr", t_ecc_clr, 1);
    chk("t3_done_op", t_done_op, 3);
    n_cnt = 1; n_aux = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (t_ecc_clr) n_cnt++;
      if (t_done || t_ecc_en) n_aux++;
    end
    chk("t3_clr_count", n_cnt, 1);
    chk("t3_clrwait_busy", t_busy, 1);
    t_ecc_rdy = 1'b1;
    tick;
    if (t_done) n_aux++;
    chk("t3_idle", t_busy, 0);
    chk("t3_no_done_en", n_aux, 0);

    // Abort coincident with core completion
    cmd_op = 2'd3; cmd_valid = 1'b1; ecc_rdy = 1'b1;
    tick; cmd_valid = 1'b0;
    tick;
    ecc_rdy = 1'b0;
    tick; tick;
    ecc_rdy = 1'b1; cmd_abort = 1'b1;
    tick; cmd_abort = 1'b0;
    chk("t4_done", done, 0);
    chk("t4_err_abort", err_abort, 1);
    chk("t4_clr", ecc_clr, 1);
    chk("t4_done_op", done_op, 3);
    tick;
    chk("t4_clr_once", {ecc_clr, done}, 0);
    tick;
    chk("t4_idle", {busy, done}, 0);
    sts_clr = 1'b1;
    tick; sts_clr = 1'b0;
    chk("t4_sts_clr", {err_to, err_abort, t_err_to}, 0);
    cmd_abort = 1'b1;
    tick; cmd_abort = 1'b0;
    chk("t4_idle_abort", {err_abort, busy, ecc_clr}, 0);

    // Reset while waiting for the core
    cmd_op = 2'd1; cmd_valid = 1'b1; ecc_rdy = 1'b1;
    tick; cmd_valid = 1'b0;
    tick;
    ecc_rdy = 1'b0;
    tick; tick;
    chk("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {busy, cmd_ready}, 2'b01);
    chk("t5_rst_outs", {ecc_clr, ecc_en, ecc_op, done_op, done}, 0);
    n_cnt = 0;
    tick; if (ecc_clr) n_cnt++;
    tick; if (ecc_clr) n_cnt++;
    chk("t5_no_clr", n_cnt, 0);
    rst_n = 1'b1;
    cmd_op = 2'd2; cmd_valid = 1'b1; ecc_rdy = 1'b1;
    tick; cmd_valid = 1'b0;
    chk("t5_en", {ecc_en, ecc_op}, 3'b110);
    tick;
    ecc_rdy = 1'b0;
    tick;
    ecc_rdy = 1'b1;
    tick;
    chk("t5_done", {done, done_op}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_cmd_issuer.md
ECC_CMD_ISSUER -- requirements
Module: ecc_cmd_issuer

Interface
REQ-001 Parameter TO_W, default 24: width of the timeout counter.
REQ-002 Parameter TO_MAX, default 24'hFFFFFF: maximum wait cycles before a timeout is declared.
REQ-003 Port clk, input, 1: the single clock; all flops on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1: host command request.
REQ-006 Port cmd_op, input, 2: ECC operation (00 ECDH_SK, 01 ECDSA_SIGN, 10 ECDSA_VERI, 11 ECDH_PK).
REQ-007 Port cmd_abort, input, 1: host abort request.
REQ-008 Port cmd_ready, output, 1: issuer can accept a command.
REQ-009 Port busy, output, 1: a command is in flight.
REQ-010 Port done, output, 1: one-cycle pulse when the command completes normally.
REQ-011 Port done_op, output, 2: op of the last completed or aborted command.
REQ-012 Port err_to, output, 1: sticky timeout flag.
REQ-013 Port err_abort, output, 1: sticky aborted flag.
REQ-014 Port sts_clr, input, 1: clears err_to and err_abort.
REQ-015 Port ecc_op, output, 2: op to core.
REQ-016 Port ecc_en, output, 1: start strobe to core.
REQ-017 Port ecc_clr, output, 1: clear strobe to core.
REQ-018 Port ecc_rdy, input, 1: core idle/ready.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CLEAR, CLR_WAIT, one-hot encoded.
REQ-020 IDLE: cmd_ready=1; cmd_valid=1 latches cmd_op into op_q, clears the timeout counter, and goes to ISSUE.
REQ-021 ISSUE: ecc_op=op_q; ecc_en=1 for exactly the cycle(s) in which ecc_rdy=1, then go to WAIT_ACK; while ecc_rdy=0, hold in ISSUE and count.
REQ-022 WAIT_ACK: on ecc_rdy=0 go to WAIT_DONE; ecc_en SHALL be 0.
REQ-023 WAIT_DONE: on ecc_rdy=1 pulse done for one cycle, set done_op=op_q, and go to IDLE.
REQ-024 Done latency SHALL be 1 cycle after the core's ecc_rdy rises; acceptance-to-ecc_en latency SHALL be 1 cycle when the core is ready.
REQ-025 The timeout counter SHALL increment every cycle in ISSUE, WAIT_ACK and WAIT_DONE, saturating.
REQ-026 When the counter reaches TO_MAX, set err_to and go to CLEAR.
REQ-027 cmd_abort in ISSUE, WAIT_ACK or WAIT_DONE SHALL set err_abort and go to CLEAR; cmd_abort in IDLE SHALL be ignored.
REQ-028 CLEAR: ecc_clr=1 for exactly one cycle, done_op=op_q, go to CLR_WAIT.
REQ-029 CLR_WAIT: go to IDLE on ecc_rdy=1; done SHALL NOT pulse.
REQ-030 If timeout and abort occur in the same cycle, both flags SHALL set, with a single CLEAR.
REQ-031 If ecc_rdy rises in WAIT_DONE in the same cycle as cmd_abort, the abort SHALL win: no done pulse, CLEAR issued.
REQ-032 busy SHALL equal NOT IDLE; cmd_ready SHALL equal IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-033 sts_clr SHALL clear both flags; a set event in the same cycle SHALL win.
REQ-034 ecc_op SHALL hold op_q in all non-IDLE states and 00 in IDLE.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, op_q=00, counter=0, done=0, done_op=00, err_to=0, err_abort=0, ecc_en=0, ecc_clr=0, ecc_op=00.
REQ-036 Reset mid-operation SHALL NOT emit ecc_clr; the core is reset by the same rst_n.

Structure
REQ-037 ECC op codes (ECDH_SK..ECDH_PK) SHALL reside in a shared package/include used with the ECC control unit.
REQ-038 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-039 cmd_op=01 with ecc_rdy=1 -> ecc_en=1 with ecc_op=01 one cycle later; after the core model drops ecc_rdy for 100 cycles and raises it -> done pulse one cycle later, done_op=01.
REQ-040 ecc_rdy held 0 while the command is issued -> ecc_en stays 0 until ecc_rdy=1, then exactly one ecc_en cycle.
REQ-041 TO_MAX=16, core never returns ecc_rdy -> err_to=1 at the 16th count, a single ecc_clr pulse, IDLE after ecc_rdy=1, no done.
REQ-042 cmd_abort in WAIT_DONE coincident with the ecc_rdy rise -> err_abort=1, ecc_clr pulse, no done; then sts_clr -> both flags 0.
REQ-043 rst_n asserted in WAIT_DONE -> all outputs take reset values immediately, no ecc_clr; the next command works normally.
